// File: rtl/vga_receiver_if.sv
`default_nettype none
// vga_receiver_if -- VGA pin bus (transmitter side) and recovered pixel bus (receiver side).
// master drives the VGA pins and observes pixels; slave is the receiver.
interface vga_receiver_if;
  logic        vga_horizontal_sync_i;
  logic        vga_vertical_sync_i;
  logic [7:0]  vga_red_i;
  logic [7:0]  vga_green_i;
  logic [7:0]  vga_blue_i;
  logic [9:0]  pixel_x_o;
  logic [9:0]  pixel_y_o;
  logic [7:0]  pixel_red_o;
  logic [7:0]  pixel_green_o;
  logic [7:0]  pixel_blue_o;
  logic        pixel_valid_o;
  logic        frame_start_o;
  logic        locked_o;
  logic [7:0]  error_count_o;
  logic [15:0] frame_crc_o;

  modport master (
    output vga_horizontal_sync_i, vga_vertical_sync_i, vga_red_i, vga_green_i, vga_blue_i,
    input  pixel_x_o, pixel_y_o, pixel_red_o, pixel_green_o, pixel_blue_o,
    input  pixel_valid_o, frame_start_o, locked_o, error_count_o, frame_crc_o
  );

  modport slave (
    input  vga_horizontal_sync_i, vga_vertical_sync_i, vga_red_i, vga_green_i, vga_blue_i,
    output pixel_x_o, pixel_y_o, pixel_red_o, pixel_green_o, pixel_blue_o,
    output pixel_valid_o, frame_start_o, locked_o, error_count_o, frame_crc_o
  );
endinterface

`default_nettype wire

// File: rtl/vga_receiver.sv
`default_nettype none
// ======================================================================================
// vga_receiver -- VGA sink: rebuilds pixel coordinates, checks line/frame timing, tracks lock.
// Optional CRC-16-CCITT frame signature under VGA_RECEIVER_CRC_EN.          Rev 1.0
// ======================================================================================
module vga_receiver #(
  parameter int H_SYNC_CYCLES       = 96,
  parameter int H_BACK_PORCH_CYCLES = 48,
  parameter int H_ACTIVE_CYCLES     = 640,
  parameter int H_TOTAL_CYCLES      = 800,
  parameter int V_SYNC_LINES        = 2,
  parameter int V_BACK_PORCH_LINES  = 33,
  parameter int V_ACTIVE_LINES      = 480,
  parameter int V_TOTAL_LINES       = 525,
  parameter int LOCK_FRAMES         = 2
) (
  input  wire logic clock_i,
  input  wire logic reset_n_i,
  vga_receiver_if.slave bus
);

  localparam logic [9:0] H_ACT_START = 10'(H_SYNC_CYCLES + H_BACK_PORCH_CYCLES);
  localparam logic [9:0] H_ACT_END   = 10'(H_SYNC_CYCLES + H_BACK_PORCH_CYCLES + H_ACTIVE_CYCLES);
  localparam logic [9:0] V_ACT_START = 10'(V_SYNC_LINES + V_BACK_PORCH_LINES);
  localparam logic [9:0] V_ACT_END   = 10'(V_SYNC_LINES + V_BACK_PORCH_LINES + V_ACTIVE_LINES);
  localparam logic [9:0] H_LAST      = 10'(H_TOTAL_CYCLES - 1);
  localparam logic [9:0] V_LAST      = 10'(V_TOTAL_LINES - 1);
  localparam logic [9:0] CNT_MAX     = 10'd1023;
  localparam logic [7:0] LOCK_N      = 8'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH = 2'd0, TRACK = 2'd1, LOCKED = 2'd2} state_t;

  logic       hs_s1, vs_s1, hs_s1_d, vs_s1_d;
  logic [7:0] red_s1, green_s1, blue_s1;
  logic       hfall, vfall;
  logic [9:0] h_count, v_count, h_next, v_next;
  logic       sat_flag, bad_seen;
  logic       sat_evt, line_bad, frame_bad, err_evt;
  state_t     state;
  logic [7:0] good_frames;
  logic       lock_gain, lock_next, active, valid_next;

  logic [9:0] pixel_x, pixel_y;
  logic [7:0] pixel_red, pixel_green, pixel_blue;
  logic       pixel_valid, frame_start, locked;
  logic [7:0] error_count;

  // Sync registers reset to the idle (high) level so a low pin after reset reads as an edge.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      hs_s1    <= 1'b1;
      vs_s1    <= 1'b1;
      hs_s1_d  <= 1'b1;
      vs_s1_d  <= 1'b1;
      red_s1   <= 8'd0;
      green_s1 <= 8'd0;
      blue_s1  <= 8'd0;
    end else begin
      hs_s1    <= bus.vga_horizontal_sync_i;
      vs_s1    <= bus.vga_vertical_sync_i;
      hs_s1_d  <= hs_s1;
      vs_s1_d  <= vs_s1;
      red_s1   <= bus.vga_red_i;
      green_s1 <= bus.vga_green_i;
      blue_s1  <= bus.vga_blue_i;
    end
  end

  assign hfall = hs_s1_d & ~hs_s1;
  assign vfall = vs_s1_d & ~vs_s1;

  always_comb begin
    h_next = hfall ? 10'd0 : ((h_count == CNT_MAX) ? h_count : h_count + 10'd1);
    v_next = v_count;
    if (vfall)
      v_next = 10'd0;
    else if (hfall && (v_count != CNT_MAX))
      v_next = v_count + 10'd1;
  end

  // A runaway line is reported once, then suppressed until the next hsync edge.
  assign sat_evt   = !hfall && (h_count == CNT_MAX) && !sat_flag;
  assign line_bad  = (hfall && (h_count != H_LAST)) || sat_evt;
  assign frame_bad = vfall && ((v_count != V_LAST) || bad_seen || line_bad);
  assign err_evt   = line_bad || frame_bad;

  assign lock_gain  = (state == TRACK) && !err_evt && vfall && ((good_frames + 8'd1) >= LOCK_N);
  assign lock_next  = ((state == LOCKED) && !err_evt) || lock_gain;
  assign active     = (h_next >= H_ACT_START) && (h_next < H_ACT_END) &&
                      (v_next >= V_ACT_START) && (v_next < V_ACT_END);
  assign valid_next = active && lock_next;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      h_count  <= 10'd0;
      v_count  <= 10'd0;
      sat_flag <= 1'b0;
      bad_seen <= 1'b0;
    end else begin
      h_count <= h_next;
      v_count <= v_next;
      if (hfall)
        sat_flag <= 1'b0;
      else if (sat_evt)
        sat_flag <= 1'b1;
      if (vfall)
        bad_seen <= 1'b0;
      else if (line_bad)
        bad_seen <= 1'b1;
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state       <= SEARCH;
      good_frames <= 8'd0;
      locked      <= 1'b0;
      error_count <= 8'd0;
    end else begin
      locked <= lock_next;
      // Coincident line and frame failures form one event, hence one increment.
      if (err_evt && (state != SEARCH) && (error_count != 8'hFF))
        error_count <= error_count + 8'd1;
      case (state)
        SEARCH: begin
          if (vfall) begin
            state       <= TRACK;
            good_frames <= 8'd0;
          end
        end
        TRACK: begin
          if (err_evt)
            state <= SEARCH;
          else if (lock_gain)
            state <= LOCKED;
          else if (vfall)
            good_frames <= good_frames + 8'd1;
        end
        LOCKED: begin
          if (err_evt)
            state <= SEARCH;
        end
        default: state <= SEARCH;
      endcase
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pixel_x     <= 10'd0;
      pixel_y     <= 10'd0;
      pixel_red   <= 8'd0;
      pixel_green <= 8'd0;
      pixel_blue  <= 8'd0;
      pixel_valid <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pixel_valid <= valid_next;
      frame_start <= valid_next && (h_next == H_ACT_START) && (v_next == V_ACT_START);
      pixel_x     <= valid_next ? (h_next - H_ACT_START) : 10'd0;
      pixel_y     <= valid_next ? (v_next - V_ACT_START) : 10'd0;
      pixel_red   <= valid_next ? red_s1   : 8'd0;
      pixel_green <= valid_next ? green_s1 : 8'd0;
      pixel_blue  <= valid_next ? blue_s1  : 8'd0;
    end
  end

`ifdef VGA_RECEIVER_CRC_EN
  logic [15:0] crc, frame_crc;

  function automatic logic [15:0] crc16_24(input logic [15:0] c_in, input logic [23:0] d);
    logic [15:0] c;
    logic        fb;
    c = c_in;
    for (int i = 23; i >= 0; i--) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      crc       <= 16'hFFFF;
      frame_crc <= 16'h0000;
    end else if (vfall) begin
      frame_crc <= crc;
      crc       <= 16'hFFFF;
    end else if (valid_next) begin
      crc <= crc16_24(crc, {red_s1, green_s1, blue_s1});
    end
  end

  assign bus.frame_crc_o = frame_crc;
`else
  assign bus.frame_crc_o = 16'h0000;
`endif

  assign bus.pixel_x_o     = pixel_x;
  assign bus.pixel_y_o     = pixel_y;
  assign bus.pixel_red_o   = pixel_red;
  assign bus.pixel_green_o = pixel_green;
  assign bus.pixel_blue_o  = pixel_blue;
  assign bus.pixel_valid_o = pixel_valid;
  assign bus.frame_start_o = frame_start;
  assign bus.locked_o      = locked;
  assign bus.error_count_o = error_count;

endmodule

`default_nettype wire

// File: tb/tb_vga_receiver.sv
`default_nettype none
// tb_vga_receiver -- directed bench for vga_receiver using a shrunken raster (20x10 clocks).
// Checks lock, pixel recovery, line/frame errors, reset, saturation and frame signature.
module tb_vga_receiver;
  localparam int HS = 4, HBP = 3, HA = 8, HT = 20;
  localparam int VS = 2, VBP = 2, VA = 4, VT = 10;
  localparam int LF = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_receiver_if bus();

  vga_receiver #(
    .H_SYNC_CYCLES(HS), .H_BACK_PORCH_CYCLES(HBP), .H_ACTIVE_CYCLES(HA), .H_TOTAL_CYCLES(HT),
    .V_SYNC_LINES(VS), .V_BACK_PORCH_LINES(VBP), .V_ACTIVE_LINES(VA), .V_TOTAL_LINES(VT),
    .LOCK_FRAMES(LF)
  ) dut (
    .clock_i(clk),
    .reset_n_i(rst_n),
    .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;
  bit zero_rgb = 1'b0;
  bit flip_last = 1'b0;

  int valid_cnt = 0;
  int fs_cnt = 0;
  logic [23:0] cap_rgb = 24'h0;
  logic [19:0] fs_xy = 20'hFFFFF;
  int snap_valid, snap_fs;
  logic [15:0] crc_zero, crc_flip;

  always @(negedge clk) begin
    if (bus.pixel_valid_o) valid_cnt++;
    if (bus.frame_start_o) begin
      fs_cnt++;
      fs_xy = {bus.pixel_x_o, bus.pixel_y_o};
    end
    if (bus.pixel_valid_o && bus.pixel_x_o == 10'd3 && bus.pixel_y_o == 10'd2)
      cap_rgb = {bus.pixel_red_o, bus.pixel_green_o, bus.pixel_blue_o};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int line, input int col);
    bus.vga_horizontal_sync_i = (col < HS) ? 1'b0 : 1'b1;
    bus.vga_vertical_sync_i   = (line < VS) ? 1'b0 : 1'b1;
    if (zero_rgb) begin
      bus.vga_red_i   = 8'h00;
      bus.vga_green_i = 8'h00;
      bus.vga_blue_i  = (flip_last && line == VS+VBP+VA-1 && col == HS+HBP+HA-1) ? 8'h01 : 8'h00;
    end else begin
      bus.vga_red_i   = 8'(col);
      bus.vga_green_i = 8'(line);
      bus.vga_blue_i  = 8'hA5 ^ 8'(col);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_line(input int line, input int from, input int to);
    for (int c = from; c < to; c++) tick(line, c);
  endtask

  task automatic drive_lines(input int first, input int last);
    for (int l = first; l <= last; l++) drive_line(l, 0, HT);
  endtask

  task automatic drive_frame(input int nlines, input int last_len);
    for (int l = 0; l < nlines; l++) drive_line(l, 0, (l == nlines-1) ? last_len : HT);
  endtask

  // Bit-serial CRC-16-CCITT over the active pixels of a zero frame, optionally with blue[0] set on the last pixel.
  function automatic logic [15:0] model_crc(input bit flip);
    logic [15:0] c;
    logic [23:0] w;
    logic        fb;
    c = 16'hFFFF;
    for (int y = 0; y < VA; y++)
      for (int x = 0; x < HA; x++) begin
        w = (flip && y == VA-1 && x == HA-1) ? 24'h000001 : 24'h000000;
        for (int i = 23; i >= 0; i--) begin
          fb = c[15] ^ w[i];
          c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
      end
    return c;
  endfunction

  initial begin
    bus.vga_horizontal_sync_i = 1'b1;
    bus.vga_vertical_sync_i   = 1'b1;
    bus.vga_red_i   = 8'h00;
    bus.vga_green_i = 8'h00;
    bus.vga_blue_i  = 8'h00;

    // Reset state
    rst_n = 1'b0;
    repeat (3) tick(5, HT-1);
    check("rst_locked", 32'(bus.locked_o), 32'd0);
    check("rst_valid", 32'(bus.pixel_valid_o), 32'd0);
    check("rst_fs", 32'(bus.frame_start_o), 32'd0);
    check("rst_err", 32'(bus.error_count_o), 32'd0);
    check("rst_xy", 32'({bus.pixel_x_o, bus.pixel_y_o}), 32'd0);
    check("rst_rgb", 32'({bus.pixel_red_o, bus.pixel_green_o, bus.pixel_blue_o}), 32'd0);
    check("rst_crc", 32'(bus.frame_crc_o), 32'd0);
    rst_n = 1'b1;

    // Acquire lock: F0 start -> TRACK, F1 start -> 1 good, F2 start -> LOCKED
    drive_frame(VT, HT);
    drive_frame(VT, HT);
    check("pre_lock", 32'(bus.locked_o), 32'd0);
    drive_frame(VT, HT);
    drive_frame(VT, HT);
    drive_frame(VT, HT);
    check("lock_after_3", 32'(bus.locked_o), 32'd1);
    snap_valid = valid_cnt;
    snap_fs = fs_cnt;
    drive_frame(VT, HT);
    check("valid_per_frame", 32'(valid_cnt - snap_valid), 32'(HA*VA));
    check("fs_per_frame", 32'(fs_cnt - snap_fs), 32'd1);
    check("fs_xy", 32'(fs_xy), 32'd0);
    check("pix_3_2_rgb", 32'(cap_rgb), 32'h000A06AF);
    check("err_clean", 32'(bus.error_count_o), 32'd0);

    // Short line (HT-1) inside a locked frame
    drive_lines(0, 5);
    drive_line(6, 0, HT-1);
    drive_line(7, 0, 1);
    check("short_line_lag1", 32'(bus.locked_o), 32'd1);
    drive_line(7, 1, 2);
    check("short_line_lag2", 32'(bus.locked_o), 32'd0);
    check("short_line_valid", 32'(bus.pixel_valid_o), 32'd0);
    check("short_line_err", 32'(bus.error_count_o), 32'd1);
    drive_line(7, 2, HT);
    drive_lines(8, 9);
    snap_valid = valid_cnt;
    drive_frame(VT, HT);
    check("track_no_valid", 32'(valid_cnt - snap_valid), 32'd0);
    check("relock_wait1", 32'(bus.locked_o), 32'd0);
    drive_frame(VT, HT);
    check("relock_wait2", 32'(bus.locked_o), 32'd0);
    drive_frame(VT, HT);
    check("relock", 32'(bus.locked_o), 32'd1);
    check("relock_err", 32'(bus.error_count_o), 32'd1);

    // Short frame (VT-1 lines) while locked
    drive_frame(VT-1, HT);
    drive_line(0, 0, 2);
    check("short_frame_lock", 32'(bus.locked_o), 32'd0);
    check("short_frame_err", 32'(bus.error_count_o), 32'd2);
    drive_line(0, 2, HT);
    drive_lines(1, VT-1);
    drive_frame(VT, HT);
    drive_frame(VT, HT);
    drive_frame(VT, HT);
    check("relock_b", 32'(bus.locked_o), 32'd1);

    // Short frame whose closing line is also short: both checks fail on the same edge
    drive_frame(VT-1, HT-1);
    drive_line(0, 0, 2);
    check("dual_fail_err", 32'(bus.error_count_o), 32'd3);
    check("dual_fail_lock", 32'(bus.locked_o), 32'd0);
    drive_line(0, 2, HT);
    drive_lines(1, VT-1);
    drive_frame(VT, HT);
    drive_frame(VT, HT);

    // hsync stuck high while locked: one error when h_count saturates
    drive_lines(0, 5);
    check("stuck_pre_lock", 32'(bus.locked_o), 32'd1);
    repeat (1100) tick(5, HT-1);
    check("stuck_err", 32'(bus.error_count_o), 32'd4);
    check("stuck_lock", 32'(bus.locked_o), 32'd0);
    drive_frame(VT, HT);
    drive_frame(VT, HT);

    // Mid-frame reset while locked
    drive_lines(0, 4);
    drive_line(5, 0, 10);
    check("pre_reset_valid", 32'(bus.pixel_valid_o), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_lock", 32'(bus.locked_o), 32'd0);
    check("async_rst_valid", 32'(bus.pixel_valid_o), 32'd0);
    check("async_rst_err", 32'(bus.error_count_o), 32'd0);
    check("async_rst_x", 32'(bus.pixel_x_o), 32'd0);
    drive_line(5, 10, 15);
    rst_n = 1'b1;
    drive_line(5, 15, HT);
    drive_lines(6, VT-1);
    drive_frame(VT, HT);
    drive_frame(VT, HT);
    check("rst_relock_wait", 32'(bus.locked_o), 32'd0);
    drive_frame(VT, HT);
    check("rst_relock", 32'(bus.locked_o), 32'd1);
    check("rst_relock_err", 32'(bus.error_count_o), 32'd0);

    // Frame signature: zero frame, then zero frame with one blue bit set on the last pixel
    zero_rgb = 1'b1;
    drive_frame(VT, HT);
    flip_last = 1'b1;
    drive_frame(VT, HT);
    zero_rgb = 1'b0;
    flip_last = 1'b0;
    crc_zero = bus.frame_crc_o;
    drive_frame(VT, HT);
    crc_flip = bus.frame_crc_o;
`ifdef VGA_RECEIVER_CRC_EN
    check("crc_zero", 32'(crc_zero), 32'(model_crc(1'b0)));
    check("crc_flip", 32'(crc_flip), 32'(model_crc(1'b1)));
    check("crc_differs", 32'(crc_flip != crc_zero), 32'd1);
`else
    check("crc_off_a", 32'(crc_zero), 32'd0);
    check("crc_off_b", 32'(crc_flip), 32'd0);
`endif

    // Saturation: each pair = vsync line (re-enter TRACK) + 5-clock bad line (one counted error)
    for (int p = 0; p < 100; p++) begin
      drive_line(0, 0, 5);
      drive_line(5, 0, 5);
    end
    check("err_100", 32'(bus.error_count_o), 32'd100);
    for (int p = 0; p < 200; p++) begin
      drive_line(0, 0, 5);
      drive_line(5, 0, 5);
    end
    check("err_sat", 32'(bus.error_count_o), 32'd255);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/vga_receiver.md
# vga_receiver

- Sink end of the VGA link produced by the pixel-timing controller.
- Samples hsync, vsync and RGB on the shared pixel clock and rebuilds the pixel coordinates.
- Checks every line and every frame against the nominal 640x480@60 timing and reports lock status.
- Sits in loopback test fixtures and in capture paths that feed a framebuffer writer.

## Interface

Parameters:

- H_SYNC_CYCLES, 96: hsync low width, in clocks.
- H_BACK_PORCH_CYCLES, 48: clocks from hsync rise to the first active pixel.
- H_ACTIVE_CYCLES, 640: active pixels per line.
- H_TOTAL_CYCLES, 800: clocks per line.
- V_SYNC_LINES, 2: vsync low width, in lines.
- V_BACK_PORCH_LINES, 33: lines from vsync rise to the first active line.
- V_ACTIVE_LINES, 480: active lines per frame.
- V_TOTAL_LINES, 525: lines per frame.
- LOCK_FRAMES, 2: consecutive good frames needed to declare lock.

Ports:

- clock_i, in, 1: pixel clock, the same clock the transmitter uses.
- reset_n_i, in, 1: reset, asynchronous, active-low.
- vga_horizontal_sync_i, in, 1: hsync, active-low pulse.
- vga_vertical_sync_i, in, 1: vsync, active-low pulse.
- vga_red_i, in, 8: red pixel data.
- vga_green_i, in, 8: green pixel data.
- vga_blue_i, in, 8: blue pixel data.
- pixel_x_o, out, 10: column of the current output pixel; 0 when not valid.
- pixel_y_o, out, 10: row of the current output pixel; 0 when not valid.
- pixel_red_o, out, 8: captured red; 0 when not valid.
- pixel_green_o, out, 8: captured green; 0 when not valid.
- pixel_blue_o, out, 8: captured blue; 0 when not valid.
- pixel_valid_o, out, 1: output pixel is active and the receiver is locked.
- frame_start_o, out, 1: one-cycle pulse on the valid pixel at (0,0).
- locked_o, out, 1: lock FSM is in LOCKED.
- error_count_o, out, 8: saturating count of timing errors.
- frame_crc_o, out, 16: signature of the last completed frame (see Configuration).

## Operation

Input stage:
- All inputs are registered once (stage S1).
- hsync fall: S1 hsync is 0 while the previous S1 hsync was 1. vsync fall is detected the same way.

h_count (10 bit):
- Set to 0 on an hsync-fall cycle, otherwise incremented by 1.
- Saturates at 1023.

v_count (10 bit):
- Set to 0 on a vsync-fall cycle. vsync fall has priority over hsync fall.
- Otherwise incremented on each hsync fall; saturates at 1023.

Line and frame checks:
- On each hsync fall, the line is good iff the pre-edge h_count == H_TOTAL_CYCLES-1.
- If h_count reaches 1023, that is a bad line, flagged once until the next hsync fall.
- On each vsync fall, the frame is good iff the pre-edge v_count == V_TOTAL_LINES-1 and no bad line occurred since the previous vsync fall.

Lock FSM:
- SEARCH (reset state) -> TRACK on vsync fall; the good-frame counter is cleared.
- TRACK: each good frame increments the counter; on reaching LOCK_FRAMES -> LOCKED.
- TRACK or LOCKED -> SEARCH on any bad line or bad frame.
- Every error event raised in TRACK or LOCKED increments error_count_o, saturating at 255. Events in SEARCH are not counted.

Active region:
- Horizontal: H_SYNC_CYCLES+H_BACK_PORCH_CYCLES <= h_count < that + H_ACTIVE_CYCLES.
- Vertical: V_SYNC_LINES+V_BACK_PORCH_LINES <= v_count < that + V_ACTIVE_LINES.
- pixel_x = h_count − 144 and pixel_y = v_count − 35 at the default parameters.
- pixel_valid_o requires the active region and locked_o=1.

## Timing

- Latency: a pin sample at cycle N appears on the outputs at cycle N+2 (S1 register, then the output register).
- All outputs are registered.
- Reset values: every output is 0, the FSM is in SEARCH, and both counters are 0.
- Reset may be asserted mid-frame. It clears everything immediately, and the receiver re-locks only after LOCK_FRAMES full good frames following the next vsync fall.
- When a line error occurs, locked_o drops on the cycle after the bad hsync fall. pixel_valid_o drops on that same cycle.
- Simultaneous hsync and vsync falls (the normal case) give one line check and one frame check in the same cycle. If both fail, the error count increments by 1, not 2.
- frame_start_o asserts only while locked.

## Configuration

VGA_RECEIVER_CRC_EN.

Defined:
- CRC-16-CCITT: polynomial 0x1021, initial value 0xFFFF, no reflection, no final XOR.
- Computed over every valid pixel. Each pixel is fed as 24 bits, MSB first: red[7]..red[0], green[7..0], blue[7..0].
- On vsync fall, frame_crc_o loads the current CRC and the CRC resets to 0xFFFF.
- frame_crc_o changes only on vsync fall.

Not defined:
- frame_crc_o is constant 0 and no CRC logic is synthesized. The port list is identical either way.

## Test plan

- Loopback from the pixel-timing controller with default parameters, after 3 frames:
  - locked_o=1 and error_count_o=0.
  - Exactly 307200 pixel_valid_o cycles per frame.
  - frame_start_o pulses once per 420000 clocks.
- Locked stream, then one line shortened to 799 clocks:
  - locked_o=0 two cycles after the short line's closing hsync edge.
  - error_count_o=1.
  - Re-lock after 2 further good frames.
- hsync held high while locked: bad-line error when h_count hits 1023, FSM goes to SEARCH, error_count_o increments once.
- Frame of 524 lines while locked: frame error at the vsync fall and error_count_o +1. If the short frame was also the frame with a bad line, the count still advances by only 1.
- Reset asserted at line 200, released 5 cycles later: all outputs 0 immediately, locked_o=0 until 2 good frames after the next vsync fall.
- Saturation: 300 injected bad lines give error_count_o=255.
- With VGA_RECEIVER_CRC_EN defined:
  - All-zero RGB frame gives frame_crc_o equal to the model value.
  - Flipping one blue bit at (639,479) changes frame_crc_o.
